// File: rtl/imem_pkg.sv
// Shared constants, error-cause encoding and index-width helper for the instruction memory.
package imem_pkg;

    // Instruction returned for any errored fetch.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Reason a fetch was rejected; kept for future error reporting.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2
    } err_cause_e;

    // Word-index width for a given depth, never below one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
module imem_array
    import imem_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 64,
    localparam int unsigned IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Program load; indices past the end of a non-power-of-2 array are dropped.
    always_ff @(posedge clk) begin
        if (we && (32'(wr_addr) < 32'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only updates on an enabled read so a stalled response keeps its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_sync_fetch.sv
// Synchronous instruction memory with valid/ready fetch, flush, error flagging and a fetch counter.
module imem_sync_fetch
    import imem_pkg::*;
#(
    parameter  int unsigned       DATA_W   = 32,
    parameter  int unsigned       ADDR_W   = 32,
    parameter  int unsigned       DEPTH    = 64,
    parameter  logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP),
    localparam int unsigned       IDX_W    = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_err,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [31:0]       fetch_cnt
);

    err_cause_e        cause;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              consume;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    // Ready depends only on the load strobe and the response slot, never on req_valid.
    assign req_ready = !prog_we && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready && !flush;
    assign consume   = rsp_valid && rsp_ready;
    assign word_idx  = req_pc >> 2;

    // Classify the incoming PC; upper address bits fall out through the range compare.
    always_comb begin
        cause = ERR_NONE;
        if (req_pc[1:0] != 2'b00) begin
            cause = ERR_ALIGN;
        end else if (word_idx >= ADDR_W'(DEPTH)) begin
            cause = ERR_RANGE;
        end
    end

    // Errored fetches skip the array so the stored word is never exposed.
    assign rd_en = accept && (cause == ERR_NONE);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (prog_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .re      (rd_en),
        .rd_addr (req_pc[IDX_W+1:2]),
        .rd_data (rd_data)
    );

    // Response slot: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
            rsp_err   <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (flush) begin
                rsp_valid <= 1'b0;
            end else if (accept) begin
                rsp_valid <= 1'b1;
                rsp_pc    <= req_pc;
                rsp_err   <= (cause != ERR_NONE);
            end else if (consume) begin
                rsp_valid <= 1'b0;
            end
            if (consume) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Both mux inputs are flop outputs, so the instruction stays glitch-free and stable on hold.
    assign rsp_instr = rsp_err ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Scoreboard bench for imem_sync_fetch: driver pushes expected responses, monitor pops on handshake.
module tb_imem_sync_fetch;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 48;
    localparam int unsigned IDX_W  = 6;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_err;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [31:0]       fetch_cnt;

    imem_sync_fetch #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOPW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .fetch_cnt (fetch_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [DEPTH];
    logic        m_valid;
    logic [31:0] m_cnt;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a fetch is legal only if word-aligned and its word number is below DEPTH.
    function automatic exp_t model_resp(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.err = (pc % 4 != 0) || ((pc / 4) >= DEPTH);
        e.instr = e.err ? NOPW : mem_m[pc / 4];
        return e;
    endfunction

    // One clock of stimulus plus the model's view of what the edge will do.
    task automatic step(input logic rv, input logic [31:0] pc, input logic fl, input logic rr,
                        input logic we, input logic [IDX_W-1:0] wa, input logic [31:0] wd);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        req_valid = rv;
        req_pc    = pc;
        flush     = fl;
        rsp_ready = rr;
        prog_we   = we;
        prog_addr = wa;
        prog_data = wd;
        #1;
        exp_ready = !we && (!m_valid || rr);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        #2;
        acc = rv && exp_ready && !fl;
        if (m_valid && rr) m_cnt = m_cnt + 32'd1;
        if (fl && m_valid && !rr && sb.size() > 0) void'(sb.pop_front());
        if (acc) sb.push_back(model_resp(pc));
        if (fl)                m_valid = 1'b0;
        else if (acc)          m_valid = 1'b1;
        else if (m_valid && rr) m_valid = 1'b0;
        if (we && (int'(wa) < DEPTH)) mem_m[wa] = wd;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 1'b0, rr, 1'b0, '0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic rr);
        step(1'b1, pc, 1'b0, rr, 1'b0, '0, 32'h0);
    endtask

    // Monitor: compare every presented response with the queue head, retire it on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual pc=%0h required=no response", rsp_pc);
                end else begin
                    e = sb[0];
                    chk("rsp_pc",    64'(rsp_pc),    64'(e.pc));
                    chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                    chk("rsp_err",   64'(rsp_err),   64'(e.err));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        int          r;
        checks    = 0;
        errors    = 0;
        m_valid   = 1'b0;
        m_cnt     = 32'd0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        #12;
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_err",   64'(rsp_err),   64'd0);
        chk("reset_instr", 64'(rsp_instr), 64'd0);
        chk("reset_pc",    64'(rsp_pc),    64'd0);
        chk("reset_cnt",   64'(fetch_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load the whole array; first four words are the known program.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, IDX_W'(i),
                 (i < 4) ? 32'(11 * (i + 1)) : $urandom);
        end
        // Writes past DEPTH must not land anywhere visible.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, IDX_W'(50), 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, IDX_W'(63), 32'hDEAD_BEEF);

        // Back-to-back fetches at full throughput.
        for (int i = 0; i < 4; i++) fetch(32'(4 * i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall: response for PC 4 held for three cycles while requests wait.
        fetch(32'd4, 1'b1);
        repeat (3) fetch(32'd8, 1'b0);
        fetch(32'd8, 1'b1);
        idle(1'b1);

        // Error cases plus the last legal word and a check that the ignored writes changed nothing.
        fetch(32'd6, 1'b1);
        fetch(32'(4 * DEPTH), 1'b1);
        fetch(32'h8000_0000, 1'b1);
        fetch(32'(4 * DEPTH - 4), 1'b1);
        fetch(32'(4 * (50 - DEPTH)), 1'b1);
        idle(1'b1);

        // Flush with an unconsumed response, then flush while consuming.
        fetch(32'd0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(1'b0);
        fetch(32'd0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b1, 1'b0, '0, 32'h0);
        idle(1'b1);

        // Program write blocks a request; the following read sees the new word.
        step(1'b1, 32'd12, 1'b0, 1'b1, 1'b1, IDX_W'(3), 32'd99);
        fetch(32'd12, 1'b1);
        idle(1'b1);

        // Randomized traffic; writes avoid words 0..3 so the known program survives.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) pc = 32'($urandom_range(DEPTH, 2000)) << 2;
            else             pc = $urandom;
            step(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                 IDX_W'($urandom_range(4, DEPTH + 15)), $urandom);
        end
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset between edges with a held response in flight.
        fetch(32'd8, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        prog_we   = 1'b0;
        rsp_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_cnt",   64'(fetch_cnt), 64'd0);
        sb.delete();
        m_valid = 1'b0;
        m_cnt   = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Memory survives reset.
        fetch(32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("refetch_model_word0", 64'(mem_m[0]), 64'd11);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
